// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared types and constants for the AES-CTR sequencer
package aes_ctr_pkg;

  localparam int BLOCK_W   = 128;
  localparam int CTR_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    KINIT,
    KWAIT,
    READY,
    GWAIT,
    OUT
  } state_e;

endpackage

// File: rtl/aes_ctr_sequencer.sv
// rtl/aes_ctr_sequencer.sv - drives a shared AES-128 core to run CTR mode over a block stream
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cfg_load_i,
  input  logic [BLOCK_W-1:0]       cfg_key_i,
  input  logic [BLOCK_W-CTR_W-1:0] cfg_nonce_i,
  input  logic [CTR_W-1:0]         cfg_ctr_init_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [BLOCK_W-1:0]       in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [BLOCK_W-1:0]       out_data_o,
  output logic                     core_init_o,
  output logic                     core_next_o,
  output logic [BLOCK_W-1:0]       core_key_o,
  output logic [BLOCK_W-1:0]       core_block_o,
  input  logic                     core_ready_i,
  input  logic [BLOCK_W-1:0]       core_result_i,
  output logic                     key_valid_o,
  output logic                     busy_o,
  output logic                     ctr_exhausted_o,
  output logic                     cfg_err_o
);

  state_e                   state_q, state_d;
  logic [BLOCK_W-1:0]       key_q, key_d;
  logic [BLOCK_W-CTR_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]         ctr_q, ctr_d;
  logic [BLOCK_W-1:0]       in_buf_q, in_buf_d;
  logic [BLOCK_W-1:0]       out_data_q, out_data_d;
  logic                     key_valid_q, key_valid_d;
  logic                     exh_q, exh_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     load_ok;
  logic                     in_ready;
  logic                     core_init;
  logic                     core_next;
  logic [CTR_W:0]           ctr_inc;

  assign ctr_inc  = {1'b0, ctr_q} + {{CTR_W{1'b0}}, 1'b1};
  assign load_ok  = cfg_load_i & ((state_q == IDLE) | (state_q == READY));
  // A simultaneous cfg_load blocks acceptance so the reload always wins.
  assign in_ready = (state_q == READY) & ~exh_q & ~cfg_load_i;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    in_buf_d    = in_buf_q;
    out_data_d  = out_data_q;
    key_valid_d = key_valid_q;
    exh_d       = exh_q;
    cfg_err_d   = cfg_load_i & ~load_ok;
    core_init   = 1'b0;
    core_next   = 1'b0;

    if (load_ok) begin
      key_d       = cfg_key_i;
      nonce_d     = cfg_nonce_i;
      ctr_d       = cfg_ctr_init_i;
      key_valid_d = 1'b0;
      exh_d       = 1'b0;
      state_d     = KINIT;
    end else begin
      case (state_q)
        IDLE: ;
        KINIT: begin
          core_init = 1'b1;
          state_d   = KWAIT;
        end
        KWAIT: begin
          if (core_ready_i) begin
            key_valid_d = 1'b1;
            state_d     = READY;
          end
        end
        READY: begin
          if (in_valid_i && in_ready) begin
            in_buf_d  = in_data_i;
            core_next = 1'b1;
            state_d   = GWAIT;
          end
        end
        GWAIT: begin
          // The counter advances only once the core has consumed the current block.
          if (core_ready_i) begin
            out_data_d = in_buf_q ^ core_result_i;
            ctr_d      = ctr_inc[CTR_W-1:0];
            if (ctr_inc[CTR_W]) begin
              exh_d = 1'b1;
            end
            state_d = OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      in_buf_q    <= '0;
      out_data_q  <= '0;
      key_valid_q <= 1'b0;
      exh_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      in_buf_q    <= in_buf_d;
      out_data_q  <= out_data_d;
      key_valid_q <= key_valid_d;
      exh_q       <= exh_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready_o      = in_ready;
  assign out_valid_o     = (state_q == OUT);
  assign out_data_o      = out_data_q;
  assign core_init_o     = core_init;
  assign core_next_o     = core_next;
  assign core_key_o      = key_q;
  assign core_block_o    = {nonce_q, ctr_q};
  assign key_valid_o     = key_valid_q;
  assign busy_o          = (state_q != IDLE) && (state_q != READY);
  assign ctr_exhausted_o = exh_q;
  assign cfg_err_o       = cfg_err_q;

endmodule
